// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-sequencer types and constants:
// state encoding, PC step, error vector, alignment.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_REQ   = 3'd1,
    S_HOLD  = 3'd2,
    S_HALT  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam logic [31:0] ERR_VECTOR  = 32'h0000_0080;
  localparam logic [31:0] ALIGN_MASK  = 32'h0000_0003;
  localparam logic [7:0]  TIMEOUT_MAX = 8'd255;

  function automatic logic misaligned(
    input logic [31:0] a
  );
    return (a & ALIGN_MASK) != 32'd0;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch controller: sequences the PC register and imem.
// Ports: clock/reset; pc_current -> next_pc (PC reg);
//   imem_req/addr/ready/rdata (memory handshake);
//   instr/instr_pc/instr_valid/dec_ready (to decode);
//   redirect/redirect_pc, halt -> halted, bus_error.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_current,
  output logic [31:0] next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        dec_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        halted,
  output logic        bus_error
);

  state_t      state;
  state_t      state_nx;
  logic [31:0] req_addr;
  logic        drop;
  logic [7:0]  tcnt;

  logic accept;
  logic resp;
  logic timeout;
  logic bad_tgt;

  assign accept  = (state == S_HOLD) & dec_ready;
  assign resp    = (state == S_REQ) & imem_ready;
  assign timeout = (state == S_REQ) & ~imem_ready
                 & (tcnt == TIMEOUT_MAX - 8'd1);
  assign bad_tgt = misaligned(redirect_pc);

  assign imem_addr = req_addr;

  always_ff @(posedge clock) begin
    if (reset) state <= S_START;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      // redirect here would leave a stale PC
      // latched, so wait for the new PC first
      S_START: if (!redirect) state_nx = S_REQ;
      S_REQ: begin
        if (resp) begin
          if (halt)
            state_nx = S_HALT;
          else if (!(drop | redirect))
            state_nx = S_HOLD;
        end else if (timeout) begin
          state_nx = S_ERR;
        end
      end
      S_HOLD: begin
        if (accept && halt)
          state_nx = S_HALT;
        else if (accept || redirect)
          state_nx = S_REQ;
      end
      S_HALT:  if (!halt) state_nx = S_START;
      S_ERR:   state_nx = S_START;
      default: state_nx = S_START;
    endcase
  end

  always_comb begin
    imem_req    = (state == S_REQ);
    instr_valid = (state == S_HOLD);
    halted      = (state == S_HALT);
    bus_error   = (redirect & bad_tgt) | timeout;
    next_pc     = pc_current;
    if (redirect)
      next_pc = bad_tgt ? ERR_VECTOR : redirect_pc;
    else if (timeout)
      next_pc = ERR_VECTOR;
    else if (accept)
      next_pc = instr_pc + PC_STEP;
  end

  // req_addr follows next_pc whenever a new
  // request begins, so imem_addr already equals
  // the PC the register is about to load
  always_ff @(posedge clock) begin
    if (reset) begin
      req_addr <= 32'd0;
      instr    <= 32'd0;
      instr_pc <= 32'd0;
      drop     <= 1'b0;
      tcnt     <= 8'd0;
    end else begin
      case (state)
        S_START: begin
          req_addr <= pc_current;
          drop     <= 1'b0;
          tcnt     <= 8'd0;
        end
        S_REQ: begin
          if (resp) begin
            tcnt <= 8'd0;
            drop <= 1'b0;
            if (!halt && !drop && !redirect) begin
              instr    <= imem_rdata;
              instr_pc <= req_addr;
            end else begin
              req_addr <= next_pc;
            end
          end else if (timeout) begin
            tcnt <= 8'd0;
            drop <= 1'b0;
          end else begin
            tcnt <= tcnt + 8'd1;
            if (redirect) drop <= 1'b1;
          end
        end
        S_HOLD: begin
          if (accept || redirect)
            req_addr <= next_pc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed
// fetch, stall, redirect, timeout, halt, wrap cases.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_current;
  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        dec_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic        bus_error;

  int n_cmp = 0;
  int n_bad = 0;
  int mem_wait = 0;
  bit mem_dead = 1'b0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_pc[$];
  logic [31:0] exp_ins[$];

  fetch_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .pc_current (pc_current),
    .next_pc    (next_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .dec_ready  (dec_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .halted     (halted),
    .bus_error  (bus_error)
  );

  always #5 clock = ~clock;

  // PC register with no enable
  always @(posedge clock)
    pc_current <= reset ? 32'd0 : next_pc;

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic push_fetch(input logic [31:0] a);
    exp_addr.push_back(a);
    exp_pc.push_back(a);
    exp_ins.push_back(mem_word(a));
  endtask

  task automatic wait_ready(input string tag);
    bit got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      step();
      @(negedge clock);
      if (imem_req && imem_ready) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s: no imem handshake in 20 cycles",
               tag);
    end
  endtask

  task automatic fetch_one(input logic [31:0] a,
                           input logic [31:0] nxt);
    push_fetch(a);
    wait_ready("fetch_handshake");
    step();
    @(negedge clock);
    chk("valid_after_ready", 32'(instr_valid), 32'd1);
    chk("next_pc_accept", next_pc, nxt);
  endtask

  // memory model: ready after mem_wait stall cycles
  initial begin
    int wcnt = 0;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset && imem_req && !mem_dead) begin
        if (wcnt >= mem_wait) begin
          imem_ready = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wcnt = 0;
        end else begin
          imem_ready = 1'b0;
          wcnt++;
        end
      end else begin
        imem_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  // monitor: memory handshakes and decode transfers
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && imem_req && imem_ready) begin
        if (exp_addr.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL addr_sb: unexpected fetch %h",
                   imem_addr);
        end else begin
          chk("addr_sb", imem_addr, exp_addr.pop_front());
        end
      end
      if (!reset && instr_valid && dec_ready) begin
        if (exp_pc.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL instr_sb: unexpected instr at %h",
                   instr_pc);
        end else begin
          chk("instr_pc_sb", instr_pc, exp_pc.pop_front());
          chk("instr_sb", instr, exp_ins.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int to_cyc;
    reset       = 1'b1;
    dec_ready   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    halt        = 1'b0;

    // reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_bus_error", 32'(bus_error), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    step();
    reset = 1'b0;

    // 1: zero-wait sequential fetch
    fetch_one(32'h0, 32'h4);
    fetch_one(32'h4, 32'h8);

    // 2: decode stall on instr_pc 8
    push_fetch(32'h8);
    wait_ready("fetch8");
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clock);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_next_pc", next_pc, 32'h8);
      chk("stall_no_req", 32'(imem_req), 32'd0);
      chk("stall_instr_pc", instr_pc, 32'h8);
    end
    step();
    dec_ready = 1'b1;
    mem_wait  = 2;
    @(negedge clock);
    chk("stall_release_next_pc", next_pc, 32'hC);

    // 3: redirect during a 3-cycle fetch
    exp_addr.push_back(32'hC);
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clock);
    chk("rd_wait1_req", 32'(imem_req), 32'd1);
    chk("rd_wait1_addr", imem_addr, 32'hC);
    chk("rd_wait1_next_pc", next_pc, 32'h40);
    step();
    redirect = 1'b0;
    @(negedge clock);
    chk("rd_wait2_addr", imem_addr, 32'hC);
    step();
    @(negedge clock);
    chk("rd_wait3_addr", imem_addr, 32'hC);
    step();
    @(negedge clock);
    chk("rd_dropped_valid", 32'(instr_valid), 32'd0);
    chk("rd_new_req", 32'(imem_req), 32'd1);
    chk("rd_new_addr", imem_addr, 32'h40);
    fetch_one(32'h40, 32'h44);
    mem_wait = 0;

    // 4: misaligned redirect in S_HOLD
    exp_addr.push_back(32'h44);
    wait_ready("fetch44");
    step();
    dec_ready   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h42;
    push_fetch(32'h80);
    @(negedge clock);
    chk("mis_bus_error", 32'(bus_error), 32'd1);
    chk("mis_next_pc", next_pc, 32'h80);
    step();
    redirect  = 1'b0;
    dec_ready = 1'b1;
    @(negedge clock);
    chk("mis_bus_error_off", 32'(bus_error), 32'd0);
    chk("mis_valid_off", 32'(instr_valid), 32'd0);
    chk("mis_req_addr", imem_addr, 32'h80);
    step();
    @(negedge clock);
    chk("mis_valid", 32'(instr_valid), 32'd1);
    chk("mis_next_pc_accept", next_pc, 32'h84);

    // 5: memory never answers
    mem_dead = 1'b1;
    to_cyc = 0;
    for (int k = 1; k <= 300 && to_cyc == 0; k++) begin
      step();
      @(negedge clock);
      if (bus_error) begin
        to_cyc = k;
        chk("to_next_pc", next_pc, 32'h80);
        chk("to_addr", imem_addr, 32'h84);
      end
    end
    chk("to_cycle", 32'(to_cyc), 32'd255);
    step();
    mem_dead = 1'b0;
    @(negedge clock);
    chk("to_err_req", 32'(imem_req), 32'd0);
    chk("to_err_bus_error", 32'(bus_error), 32'd0);
    step();
    @(negedge clock);
    chk("to_start_req", 32'(imem_req), 32'd0);
    fetch_one(32'h80, 32'h84);

    // 6: halt with a fetch outstanding
    mem_wait = 2;
    exp_addr.push_back(32'h84);
    step();
    halt = 1'b1;
    @(negedge clock);
    chk("halt_req_kept", 32'(imem_req), 32'd1);
    chk("halt_not_yet", 32'(halted), 32'd0);
    step();
    @(negedge clock);
    chk("halt_req_kept2", 32'(imem_req), 32'd1);
    step();
    @(negedge clock);
    chk("halt_resp_cycle", 32'(halted), 32'd0);
    step();
    mem_wait = 0;
    @(negedge clock);
    chk("halted", 32'(halted), 32'd1);
    chk("halted_valid", 32'(instr_valid), 32'd0);
    chk("halted_req", 32'(imem_req), 32'd0);
    chk("halted_next_pc", next_pc, 32'h84);
    repeat (2) begin
      step();
      @(negedge clock);
      chk("halted_hold", 32'(halted), 32'd1);
      chk("halted_pc_frozen", next_pc, 32'h84);
    end
    step();
    halt = 1'b0;
    @(negedge clock);
    chk("halt_release_cycle", 32'(halted), 32'd1);
    step();
    @(negedge clock);
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_start_req", 32'(imem_req), 32'd0);
    fetch_one(32'h84, 32'h88);

    // 7: redirect with response, then PC wrap
    exp_addr.push_back(32'h88);
    step();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    push_fetch(32'hFFFF_FFFC);
    @(negedge clock);
    chk("wrap_rd_next_pc", next_pc, 32'hFFFF_FFFC);
    chk("wrap_rd_bus_error", 32'(bus_error), 32'd0);
    step();
    redirect = 1'b0;
    @(negedge clock);
    chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_dropped_valid", 32'(instr_valid), 32'd0);
    step();
    @(negedge clock);
    chk("wrap_valid", 32'(instr_valid), 32'd1);
    chk("wrap_next_pc", next_pc, 32'h0);
    mem_dead = 1'b1;

    repeat (3) step();
    @(negedge clock);
    chk("addr_sb_left", 32'(exp_addr.size()), 32'd0);
    chk("instr_sb_left", 32'(exp_pc.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
